// File: rtl/cpu_pkg.sv
// Shared definitions for the SIMPLE core phase sequencer.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IF    = 3'd1,
        ST_ID    = 3'd2,
        ST_EX    = 3'd3,
        ST_MEM   = 3'd4,
        ST_WB    = 3'd5,
        ST_HALT  = 3'd6,
        ST_ERROR = 3'd7
    } state_t;

    localparam int unsigned PHASE_W = 5;
    localparam int unsigned PH_IF   = 0;
    localparam int unsigned PH_ID   = 1;
    localparam int unsigned PH_EX   = 2;
    localparam int unsigned PH_MEM  = 3;
    localparam int unsigned PH_WB   = 4;

    // One-hot phase vector for a sequencer state; all-zero outside IF..WB.
    function automatic logic [PHASE_W-1:0] phase_of(input state_t s);
        logic [PHASE_W-1:0] v;
        v = '0;
        case (s)
            ST_IF:   v[PH_IF]  = 1'b1;
            ST_ID:   v[PH_ID]  = 1'b1;
            ST_EX:   v[PH_EX]  = 1'b1;
            ST_MEM:  v[PH_MEM] = 1'b1;
            ST_WB:   v[PH_WB]  = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a level control input (front-panel switch).
module edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    // Remember last cycle's level so a held switch yields a single pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_prev <= 1'b0;
        else        r_prev <= i_level;
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB phase sequencer with run/stop, single-step,
// HLT handling, data-memory wait with timeout and retired-instruction count.
module phase_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   exec,
    input  logic                   step,
    input  logic                   halt,
    input  logic                   reg_write,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic                   mem_ready,
    output logic [PHASE_W-1:0]     phase,
    output logic                   ir_we,
    output logic                   pc_we,
    output logic                   rf_we,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic                   running,
    output logic                   halted,
    output logic                   bus_error,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    localparam int unsigned         WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]   WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_running;
    logic                   w_running_nxt;
    logic [WAIT_W-1:0]      r_wait_cnt;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_exec_rise;
    logic                   w_step_rise;
    logic                   w_access;
    logic                   w_wait_active;

    edge_detect u_exec_edge (
        .clock   (clock),
        .reset   (reset),
        .i_level (exec),
        .o_rise  (w_exec_rise)
    );

    edge_detect u_step_edge (
        .clock   (clock),
        .reset   (reset),
        .i_level (step),
        .o_rise  (w_step_rise)
    );

    assign w_access      = mem_read | mem_write;
    assign w_wait_active = (r_state == ST_MEM) && (r_wait_cnt < WAIT_MAX);

    // Next state and run-mode decision; running is resolved first so a stop
    // request seen in WB already sends the sequencer to IDLE.
    always_comb begin
        w_running_nxt = r_running;
        if (w_exec_rise) begin
            if (r_running)               w_running_nxt = 1'b0;
            else if (r_state == ST_IDLE) w_running_nxt = 1'b1;
        end

        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_exec_rise)                   w_next = ST_IF;
                else if (w_step_rise && !r_running) w_next = ST_IF;
            end
            ST_IF:  w_next = ST_ID;
            ST_ID:  w_next = ST_EX;
            ST_EX:  w_next = halt ? ST_HALT : ST_MEM;
            ST_MEM: begin
                if (!w_access || mem_ready)     w_next = ST_WB;
                else if (r_wait_cnt == WAIT_LAST) w_next = ST_ERROR;
            end
            ST_WB:    w_next = w_running_nxt ? ST_IF : ST_IDLE;
            ST_HALT:  w_next = ST_HALT;
            ST_ERROR: w_next = ST_ERROR;
            default:  w_next = ST_IDLE;
        endcase

        if (w_next == ST_HALT || w_next == ST_ERROR) w_running_nxt = 1'b0;
    end

    // State, run flag, MEM wait counter and retired-instruction counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_running  <= 1'b0;
            r_wait_cnt <= '0;
            r_count    <= '0;
        end else begin
            r_state   <= w_next;
            r_running <= w_running_nxt;
            if (r_state == ST_MEM && w_next == ST_MEM) r_wait_cnt <= r_wait_cnt + 1'b1;
            else                                       r_wait_cnt <= '0;
            if (r_state == ST_WB) r_count <= r_count + 1'b1;
        end
    end

    // Strobes gated into their phase; a load/store conflict resolves to read.
    always_comb begin
        phase       = phase_of(r_state);
        ir_we       = (r_state == ST_IF);
        pc_we       = (r_state == ST_WB);
        rf_we       = (r_state == ST_WB) & reg_write;
        mem_re      = w_wait_active & mem_read;
        mem_we      = w_wait_active & mem_write & ~mem_read;
        running     = r_running;
        halted      = (r_state == ST_HALT) || (r_state == ST_ERROR);
        bus_error   = (r_state == ST_ERROR);
        instr_count = r_count;
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer.
module tb_phase_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        exec, step, halt, reg_write, mem_read, mem_write, mem_ready;
    logic [4:0]  phase;
    logic        ir_we, pc_we, rf_we, mem_re, mem_we;
    logic        running, halted, bus_error;
    logic [15:0] instr_count;

    int total = 0;
    int bad   = 0;

    localparam logic [4:0] P_IDLE = 5'b00000;
    localparam logic [4:0] P_IF   = 5'b00001;
    localparam logic [4:0] P_ID   = 5'b00010;
    localparam logic [4:0] P_EX   = 5'b00100;
    localparam logic [4:0] P_MEM  = 5'b01000;
    localparam logic [4:0] P_WB   = 5'b10000;

    always #5 clock = ~clock;

    phase_sequencer #(
        .COUNT_WIDTH (16),
        .MEM_TIMEOUT (15)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .exec        (exec),
        .step        (step),
        .halt        (halt),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_ready   (mem_ready),
        .phase       (phase),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .rf_we       (rf_we),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .running     (running),
        .halted      (halted),
        .bus_error   (bus_error),
        .instr_count (instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Settle, then check phase and all strobes for the current cycle.
    task automatic obs(input string tag, input logic [4:0] ph, input logic ir,
                       input logic pc, input logic rf, input logic re, input logic we);
        #1;
        chk({tag, "_phase"},  32'(phase),  32'(ph));
        chk({tag, "_ir_we"},  32'(ir_we),  32'(ir));
        chk({tag, "_pc_we"},  32'(pc_we),  32'(pc));
        chk({tag, "_rf_we"},  32'(rf_we),  32'(rf));
        chk({tag, "_mem_re"}, 32'(mem_re), 32'(re));
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(we));
    endtask

    task automatic adv();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset = 1'b0; exec = 1'b0; step = 1'b0; halt = 1'b0;
        reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_ready = 1'b0;

        // Reset state
        obs("rst", P_IDLE, 0, 0, 0, 0, 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_halted",  32'(halted), 0);
        chk("rst_buserr",  32'(bus_error), 0);
        chk("rst_count",   32'(instr_count), 0);
        repeat (2) adv();
        reset = 1'b1;
        adv();

        // Single step, non-memory instruction: 5 cycles
        step = 1'b1;
        obs("t1_idle", P_IDLE, 0, 0, 0, 0, 0);
        adv(); step = 1'b0;
        obs("t1_if",  P_IF,  1, 0, 0, 0, 0); adv();
        obs("t1_id",  P_ID,  0, 0, 0, 0, 0); adv();
        obs("t1_ex",  P_EX,  0, 0, 0, 0, 0); adv();
        obs("t1_mem", P_MEM, 0, 0, 0, 0, 0); adv();
        obs("t1_wb",  P_WB,  0, 1, 0, 0, 0);
        chk("t1_wb_count", 32'(instr_count), 0);
        adv();
        obs("t1_done", P_IDLE, 0, 0, 0, 0, 0);
        chk("t1_count",   32'(instr_count), 1);
        chk("t1_running", 32'(running), 0);

        // Free run, stop requested during EX of the 4th instruction
        exec = 1'b1;
        obs("t2_idle", P_IDLE, 0, 0, 0, 0, 0);
        adv(); exec = 1'b0;
        for (int n = 0; n < 4; n++) begin
            for (int p = 0; p < 5; p++) begin
                if (n == 3 && p == 2) exec = 1'b1;
                obs($sformatf("t2_i%0d_p%0d", n, p), 5'(1 << p), p == 0, p == 4, 0, 0, 0);
                chk($sformatf("t2_i%0d_p%0d_run", n, p), 32'(running),
                    (n < 3 || p <= 2) ? 1 : 0);
                adv();
            end
        end
        obs("t2_done", P_IDLE, 0, 0, 0, 0, 0);
        chk("t2_count",   32'(instr_count), 5);
        chk("t2_running", 32'(running), 0);
        adv();
        obs("t2_stay", P_IDLE, 0, 0, 0, 0, 0);
        exec = 1'b0;

        // Load with register write, mem_ready on the 3rd MEM cycle: 7 cycles
        step = 1'b1; mem_read = 1'b1; reg_write = 1'b1;
        obs("t3_idle", P_IDLE, 0, 0, 0, 0, 0);
        adv(); step = 1'b0;
        obs("t3_if", P_IF, 1, 0, 0, 0, 0); adv();
        mem_ready = 1'b1;
        obs("t3_id", P_ID, 0, 0, 0, 0, 0); adv();
        mem_ready = 1'b0;
        obs("t3_ex",   P_EX,  0, 0, 0, 0, 0); adv();
        obs("t3_mem1", P_MEM, 0, 0, 0, 1, 0); adv();
        obs("t3_mem2", P_MEM, 0, 0, 0, 1, 0); adv();
        mem_ready = 1'b1;
        obs("t3_mem3", P_MEM, 0, 0, 0, 1, 0); adv();
        mem_ready = 1'b0;
        obs("t3_wb", P_WB, 0, 1, 1, 0, 0);
        chk("t3_wb_count", 32'(instr_count), 5);
        adv();
        obs("t3_done", P_IDLE, 0, 0, 0, 0, 0);
        chk("t3_count", 32'(instr_count), 6);
        mem_read = 1'b0; reg_write = 1'b0;

        // exec and step edges together (exec wins), then HLT in EX
        exec = 1'b1; step = 1'b1;
        obs("t4_idle", P_IDLE, 0, 0, 0, 0, 0);
        adv(); exec = 1'b0; step = 1'b0;
        obs("t4_if", P_IF, 1, 0, 0, 0, 0);
        chk("t4_running", 32'(running), 1);
        adv();
        halt = 1'b1; reg_write = 1'b1;
        obs("t4_id", P_ID, 0, 0, 0, 0, 0); adv();
        obs("t4_ex", P_EX, 0, 0, 0, 0, 0); adv();
        obs("t4_halt", P_IDLE, 0, 0, 0, 0, 0);
        chk("t4_halted",     32'(halted), 1);
        chk("t4_halt_run",   32'(running), 0);
        chk("t4_halt_buserr", 32'(bus_error), 0);
        exec = 1'b1; adv();
        exec = 1'b0; step = 1'b1; adv();
        step = 1'b0;
        obs("t4_sticky", P_IDLE, 0, 0, 0, 0, 0);
        chk("t4_sticky_halted", 32'(halted), 1);
        chk("t4_sticky_run",    32'(running), 0);
        chk("t4_sticky_count",  32'(instr_count), 6);
        halt = 1'b0; reg_write = 1'b0;

        // Reset out of HALT
        reset = 1'b0;
        obs("t5_rst", P_IDLE, 0, 0, 0, 0, 0);
        chk("t5_rst_halted", 32'(halted), 0);
        chk("t5_rst_count",  32'(instr_count), 0);
        adv(); reset = 1'b1; adv();

        // Store with mem_ready held low: 15 wait cycles then bus error
        step = 1'b1; mem_write = 1'b1;
        obs("t5_idle", P_IDLE, 0, 0, 0, 0, 0);
        adv(); step = 1'b0;
        obs("t5_if", P_IF, 1, 0, 0, 0, 0); adv();
        obs("t5_id", P_ID, 0, 0, 0, 0, 0); adv();
        obs("t5_ex", P_EX, 0, 0, 0, 0, 0); adv();
        for (int k = 0; k < 15; k++) begin
            obs($sformatf("t5_mem%0d", k), P_MEM, 0, 0, 0, 0, 1);
            chk($sformatf("t5_mem%0d_buserr", k), 32'(bus_error), 0);
            adv();
        end
        obs("t5_err", P_IDLE, 0, 0, 0, 0, 0);
        chk("t5_err_buserr", 32'(bus_error), 1);
        chk("t5_err_halted", 32'(halted), 1);
        chk("t5_err_count",  32'(instr_count), 0);
        mem_write = 1'b0;

        // Asynchronous reset in the middle of a free-running MEM wait
        reset = 1'b0; adv(); reset = 1'b1; adv();
        exec = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
        obs("t6_idle", P_IDLE, 0, 0, 0, 0, 0);
        adv(); exec = 1'b0;
        obs("t6_if", P_IF, 1, 0, 0, 0, 0); adv();
        obs("t6_id", P_ID, 0, 0, 0, 0, 0); adv();
        obs("t6_ex", P_EX, 0, 0, 0, 0, 0); adv();
        obs("t6_mem", P_MEM, 0, 0, 0, 1, 0);
        chk("t6_mem_run", 32'(running), 1);
        reset = 1'b0;
        obs("t6_abort", P_IDLE, 0, 0, 0, 0, 0);
        chk("t6_abort_run",    32'(running), 0);
        chk("t6_abort_halted", 32'(halted), 0);
        chk("t6_abort_buserr", 32'(bus_error), 0);
        chk("t6_abort_count",  32'(instr_count), 0);
        adv(); reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        adv();
        obs("t6_after", P_IDLE, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Multi-cycle phase sequencer for the 16-bit SIMPLE processor core. It steps the datapath through IF, ID, EX, MEM and WB phases and gates the decoded write and memory strobes from the instruction decoder into their phase. It implements the front-panel run/stop and single-step controls, halts on HLT, waits on the data-memory handshake, and counts retired instructions.

## Interface
- COUNT_WIDTH, 16, width of the retired-instruction counter
- MEM_TIMEOUT, 15, maximum MEM-phase wait cycles before bus error (≥1, ≤255)

- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- exec  in  1  run/stop toggle, level; rising edge is the request
- step  in  1  single-step request, level; rising edge is the request
- halt  in  1  decoded HLT for the instruction in IR
- reg_write  in  1  decoded register-file write for the instruction in IR
- mem_read  in  1  decoded load
- mem_write  in  1  decoded store
- mem_ready  in  1  data-memory completion for the current access
- phase  out  5  one-hot {WB,MEM,EX,ID,IF}; 0 when idle/halted/error
- ir_we  out  1  instruction-register load
- pc_we  out  1  PC update (sequential or branch target)
- rf_we  out  1  register-file write
- mem_re  out  1  data-memory read strobe
- mem_we  out  1  data-memory write strobe
- running  out  1  free-run mode active
- halted  out  1  HLT executed or bus error
- bus_error  out  1  MEM timeout occurred
- instr_count  out  COUNT_WIDTH  retired instructions, wraps

## Operation
- Rising edges of exec and step are detected against a registered previous value. Both previous values reset to 0.
- States: IDLE, IF, ID, EX, MEM, WB, HALT, ERROR. Reset enters IDLE.
- IDLE: an exec edge sets running=1 and moves to IF. A step edge with running=0 moves to IF and executes exactly one instruction. If both edges occur in the same cycle, exec wins.
- IF → ID → EX each take one cycle.
- EX: if halt=1, go to HALT. No MEM/WB follows and pc_we is never asserted. Otherwise go to MEM.
- MEM: if mem_read or mem_write is set, mem_re or mem_we is held until the cycle in which mem_ready=1, then go to WB. If neither is set, MEM lasts one cycle. If both are set, the access is treated as a read.
- MEM wait counter: when it reaches MEM_TIMEOUT cycles without mem_ready, go to ERROR with bus_error=1 and halted=1. rf_we and pc_we stay 0.
- WB: pc_we=1, rf_we=reg_write, instr_count increments by 1 (modulo 2^COUNT_WIDTH). Next state is IF if running=1 at the WB cycle, else IDLE.
- An exec edge while running=1 in any state clears running. The current instruction completes through WB, then the sequencer enters IDLE.
- A step edge while running=1 is ignored.
- HALT and ERROR are sticky and exit only via reset. exec and step edges are ignored, and running is cleared on entry.
- Strobe decode:
  - ir_we = IF
  - mem_re = MEM & mem_read & wait-active
  - mem_we = MEM & mem_write & ~mem_read & wait-active
  - rf_we = WB & reg_write
  - pc_we = WB
- The strobes are combinational from registered state and decoder inputs. They are never asserted outside their phase.

## Timing
- Reset values: phase=0, all strobes 0, running=0, halted=0, bus_error=0, instr_count=0, wait counter=0.
- Reset is asynchronous on assertion. Deassertion is synchronized externally, so the first active edge is clean.
- Non-memory instruction: 5 cycles (IF..WB).
- Memory instruction: 4 + k cycles, where k ≥ 1 is the cycle in MEM at which mem_ready is high. mem_ready high in the first MEM cycle gives k=1.
- mem_ready is ignored outside MEM.
- Edge-to-IF latency: request edge at input in cycle n produces phase=IF in cycle n+1.
- instr_count is updated at the end of the WB cycle and is visible the following cycle.
- Reset mid-instruction aborts immediately. No strobe is asserted after reset assertion.

## Structure
- Shared package (cpu_pkg): state enum, one-hot phase bit indices (PH_IF..PH_WB).
- Sub-module edge_detect (one instance per exec/step): registered previous value, rising-edge pulse output.
- Wait counter width is $clog2(MEM_TIMEOUT+1).

## Test plan
- Reset, then one step edge with all decoder inputs 0: phase walks IF,ID,EX,MEM,WB over 5 cycles, pc_we=1 only in WB, instr_count=1, then IDLE.
- exec edge, 3 non-memory instructions, exec edge during EX of the 4th: 4 instructions complete, instr_count=4, running=0, phase=0.
- Load with mem_ready asserted 3 cycles into MEM: mem_re high exactly 3 cycles, WB follows, rf_we=1 when reg_write=1; instruction takes 7 cycles.
- halt=1 during EX: next state HALT with halted=1, pc_we and rf_we never pulse, and subsequent exec/step edges leave phase=0.
- Store with mem_ready held 0 and MEM_TIMEOUT=15: mem_we high 15 cycles, then bus_error=1, halted=1, and instr_count is unchanged.
- exec and step edges in the same IDLE cycle: running=1. Asynchronous reset asserted mid-MEM: all outputs return to reset values in the same cycle.
